// File: rtl/tt_sweep_pkg.sv
// Shared types and defaults for the truth-table sweeper.
//   sweep_state_e   : sweep FSM state encoding
//   DefNIn          : default number of gate-under-test inputs
//   DefSettleCycles : default hold time per input combination
//   tt_rows(n)      : number of truth-table rows for n inputs (2**n)
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StApply,
        StSample,
        StFinish
    } sweep_state_e;

    localparam int unsigned DefNIn          = 3;
    localparam int unsigned DefSettleCycles = 4;

    function automatic int unsigned tt_rows(input int unsigned n);
        return 32'd1 << n;
    endfunction

endpackage

// File: rtl/settle_counter.sv
// Hold timer for one truth-table row.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   clr_i : return the count to zero (wins over en_i)
//   en_i  : advance the count by one
//   tc_o  : count has reached MaxCount-1, i.e. the row has been held MaxCount cycles
module settle_counter #(
    parameter int unsigned MaxCount = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    // Wide enough to hold MaxCount: the count steps once past terminal before being cleared.
    localparam int unsigned             CntW  = $clog2(MaxCount + 1);
    localparam logic [CntW-1:0]         TcVal = CntW'(MaxCount - 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tc_o = (cnt_q == TcVal);

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every input combination of an N_IN-input gate in ascending order, holds each for
// SETTLE_CYCLES, samples the gate output and compares the assembled table to an expected one.
//   clk           : clock, rising edge
//   rst           : synchronous active-high reset
//   start         : begin a sweep (only looked at while idle)
//   expected      : expected table, bit i = gate output for stim == i; latched on start
//   stim          : gate inputs, MSB-first (stim[N_IN-1] -> first gate input)
//   gut_out       : gate output, assumed synchronous to clk
//   busy          : sweep in progress
//   done          : one-cycle pulse at the end of a sweep
//   pass          : observed table matched expected; valid from done until next start
//   observed      : captured table, bit i = gut_out sampled while stim == i
//   mismatch_mask : observed ^ latched expected; valid with pass
module truth_table_sweeper
    import tt_sweep_pkg::*;
#(
    parameter int unsigned N_IN          = DefNIn,
    parameter int unsigned SETTLE_CYCLES = DefSettleCycles
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [tt_rows(N_IN)-1:0]    expected,
    output logic [N_IN-1:0]             stim,
    input  logic                        gut_out,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [tt_rows(N_IN)-1:0]    observed,
    output logic [tt_rows(N_IN)-1:0]    mismatch_mask
);

    localparam int unsigned     Rows    = tt_rows(N_IN);
    localparam logic [N_IN-1:0] LastIdx = N_IN'(Rows - 1);

    sweep_state_e    state_q;
    logic [N_IN-1:0] idx_q;
    logic [Rows-1:0] exp_q;
    logic [Rows-1:0] observed_q;
    logic [Rows-1:0] mismatch_q;
    logic            busy_q;
    logic            done_q;
    logic            pass_q;

    logic cnt_clr;
    logic cnt_en;
    logic cnt_tc;

    // Timer restarts at each row: held at zero while idle and during the sample cycle.
    assign cnt_clr = (state_q == StIdle) || (state_q == StSample);
    assign cnt_en  = (state_q == StApply);

    settle_counter #(
        .MaxCount (SETTLE_CYCLES)
    ) u_settle_counter (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .tc_o  (cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            exp_q      <= '0;
            observed_q <= '0;
            mismatch_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        idx_q      <= '0;
                        observed_q <= '0;
                        exp_q      <= expected;
                        busy_q     <= 1'b1;
                        state_q    <= StApply;
                    end
                end
                StApply: begin
                    if (cnt_tc) begin
                        state_q <= StSample;
                    end
                end
                StSample: begin
                    observed_q[idx_q] <= gut_out;
                    // Terminal compare instead of a carry bit: stim parks on the last row.
                    if (idx_q != LastIdx) begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= StApply;
                    end else begin
                        state_q <= StFinish;
                    end
                end
                StFinish: begin
                    done_q     <= 1'b1;
                    pass_q     <= (observed_q == exp_q);
                    mismatch_q <= observed_q ^ exp_q;
                    busy_q     <= 1'b0;
                    state_q    <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign stim          = idx_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign observed      = observed_q;
    assign mismatch_mask = mismatch_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Instance A: SETTLE_CYCLES=4, combinational gate model
    logic       rst_a, start_a, gut_out_a, busy_a, done_a, pass_a;
    logic [7:0] expected_a, observed_a, mask_a, tbl_a;
    logic [2:0] stim_a;

    // Instance B: SETTLE_CYCLES=1, combinational or 2-cycle-delayed gate model
    logic       rst_b, start_b, gut_out_b, busy_b, done_b, pass_b, dly_sel_b;
    logic [7:0] expected_b, observed_b, mask_b, tbl_b;
    logic [2:0] stim_b;
    logic       d1_b, d2_b;

    // Instance C: SETTLE_CYCLES=3, 2-cycle-delayed gate model
    logic       rst_c, start_c, gut_out_c, busy_c, done_c, pass_c;
    logic [7:0] expected_c, observed_c, mask_c, tbl_c;
    logic [2:0] stim_c;
    logic       d1_c, d2_c;

    assign gut_out_a = tbl_a[stim_a];
    assign gut_out_b = dly_sel_b ? d2_b : tbl_b[stim_b];
    assign gut_out_c = d2_c;

    always @(posedge clk) begin
        d1_b <= tbl_b[stim_b];
        d2_b <= d1_b;
        d1_c <= tbl_c[stim_c];
        d2_c <= d1_c;
    end

    truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(4)) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .expected(expected_a), .stim(stim_a),
        .gut_out(gut_out_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .observed(observed_a), .mismatch_mask(mask_a)
    );

    truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .expected(expected_b), .stim(stim_b),
        .gut_out(gut_out_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .observed(observed_b), .mismatch_mask(mask_b)
    );

    truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(3)) dut_c (
        .clk(clk), .rst(rst_c), .start(start_c), .expected(expected_c), .stim(stim_c),
        .gut_out(gut_out_c), .busy(busy_c), .done(done_c), .pass(pass_c),
        .observed(observed_c), .mismatch_mask(mask_c)
    );

    // One full sweep on A. Stim row r is entered at accept edge + 5r; done after edge 41.
    task automatic sweep_a(input logic [7:0] exp_tbl, input logic exp_pass,
                           input logic [7:0] exp_obs, input logic [7:0] exp_mask,
                           input int repulse_k, input string name);
        logic [2:0] exp_stim;
        expected_a = exp_tbl;
        start_a    = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int k = 0; k <= 40; k++) begin
            if (k > 0) @(negedge clk);
            exp_stim = 3'(((k / 5) > 7) ? 7 : (k / 5));
            n_vec++;
            if ({stim_a, busy_a, done_a} !== {exp_stim, 1'b1, 1'b0}) begin
                n_err++;
                $display("FAIL %s_step%0d: stim/busy/done got %0d/%b/%b want %0d/1/0",
                         name, k, stim_a, busy_a, done_a, exp_stim);
            end
            if (k == 20) expected_a = ~exp_tbl;
            start_a = (k == repulse_k);
        end
        @(negedge clk);
        start_a = 1'b0;
        n_vec++;
        if ({done_a, busy_a, pass_a, observed_a, mask_a} !==
            {1'b1, 1'b0, exp_pass, exp_obs, exp_mask}) begin
            n_err++;
            $display("FAIL %s_result: done/busy/pass/obs/mask got %b/%b/%b/%h/%h want 1/0/%b/%h/%h",
                     name, done_a, busy_a, pass_a, observed_a, mask_a, exp_pass, exp_obs,
                     exp_mask);
        end
        @(negedge clk);
        n_vec++;
        if ({done_a, busy_a, stim_a} !== {1'b0, 1'b0, 3'd7}) begin
            n_err++;
            $display("FAIL %s_after: done/busy/stim got %b/%b/%0d want 0/0/7",
                     name, done_a, busy_a, stim_a);
        end
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({stim_a, busy_a, done_a, pass_a, observed_a, mask_a} !== 22'd0) begin
            n_err++;
            $display("FAIL reset_a: stim/busy/done/pass/obs/mask got %0d/%b/%b/%b/%h/%h want all 0",
                     stim_a, busy_a, done_a, pass_a, observed_a, mask_a);
        end
        n_vec++;
        if ({stim_b, busy_b, done_b, pass_b, observed_b, mask_b,
             stim_c, busy_c, done_c, pass_c, observed_c, mask_c} !== 44'd0) begin
            n_err++;
            $display("FAIL reset_bc: busy_b/obs_b/busy_c/obs_c got %b/%h/%b/%h want 0/00/0/00",
                     busy_b, observed_b, busy_c, observed_c);
        end
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({busy_a, done_a, stim_a} !== 5'd0) begin
            n_err++;
            $display("FAIL idle_no_start: busy/done/stim got %b/%b/%0d want 0/0/0",
                     busy_a, done_a, stim_a);
        end
    endtask

    task automatic test_basic();
        tbl_a = 8'h58;
        sweep_a(8'h58, 1'b1, 8'h58, 8'h00, -1, "basic");
        tbl_a = 8'hC3;
        sweep_a(8'h3C, 1'b0, 8'hC3, 8'hFF, -1, "inverted");
    endtask

    task automatic test_mismatch();
        tbl_a = 8'h58;
        sweep_a(8'h5A, 1'b0, 8'h58, 8'h02, -1, "mismatch");
    endtask

    task automatic test_restart_ignored();
        tbl_a = 8'h58;
        sweep_a(8'h58, 1'b1, 8'h58, 8'h00, 10, "restart_mid");
        sweep_a(8'h58, 1'b1, 8'h58, 8'h00, 40, "restart_finish");
    endtask

    task automatic test_rst_mid();
        logic seen;
        tbl_a      = 8'hFF;
        expected_a = 8'hFF;
        start_a    = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (15) @(negedge clk);
        n_vec++;
        if ({stim_a, busy_a, observed_a} !== {3'd3, 1'b1, 8'h07}) begin
            n_err++;
            $display("FAIL pre_abort: stim/busy/obs got %0d/%b/%h want 3/1/07",
                     stim_a, busy_a, observed_a);
        end
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        n_vec++;
        if ({stim_a, busy_a, done_a, pass_a, observed_a, mask_a} !== 22'd0) begin
            n_err++;
            $display("FAIL abort: stim/busy/done/pass/obs/mask got %0d/%b/%b/%b/%h/%h want all 0",
                     stim_a, busy_a, done_a, pass_a, observed_a, mask_a);
        end
        seen = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (done_a || busy_a) seen = 1'b1;
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL abort_quiet: done/busy activity got %b want 0", seen);
        end
    endtask

    // SETTLE_CYCLES=1, start held: done after edges 17, 35, 53. Middle sweep latches 5A.
    task automatic test_back_to_back();
        logic exp_done;
        logic exp_pass;
        logic [7:0] exp_mask;
        tbl_b      = 8'h58;
        expected_b = 8'h58;
        dly_sel_b  = 1'b0;
        start_b    = 1'b1;
        for (int k = 0; k <= 53; k++) begin
            @(negedge clk);
            exp_done = (k == 17) || (k == 35) || (k == 53);
            n_vec++;
            if ({done_b, busy_b} !== {exp_done, ~exp_done}) begin
                n_err++;
                $display("FAIL b2b_cycle%0d: done/busy got %b/%b want %b/%b",
                         k, done_b, busy_b, exp_done, ~exp_done);
            end
            if (exp_done) begin
                exp_pass = (k != 35);
                exp_mask = (k == 35) ? 8'h02 : 8'h00;
                n_vec++;
                if ({pass_b, observed_b, mask_b} !== {exp_pass, 8'h58, exp_mask}) begin
                    n_err++;
                    $display("FAIL b2b_result%0d: pass/obs/mask got %b/%h/%h want %b/58/%h",
                             k, pass_b, observed_b, mask_b, exp_pass, exp_mask);
                end
            end
            if (k == 5)  expected_b = 8'h5A;
            if (k == 20) expected_b = 8'h58;
            if (k == 53) start_b = 1'b0;
        end
        @(negedge clk);
        n_vec++;
        if ({done_b, busy_b} !== 2'b00) begin
            n_err++;
            $display("FAIL b2b_stop: done/busy got %b/%b want 0/0", done_b, busy_b);
        end
    endtask

    task automatic test_delay();
        int cyc;
        // B: one settle cycle is too short for a 2-cycle gate; each row sees the previous row.
        tbl_b      = 8'h58;
        expected_b = 8'h58;
        dly_sel_b  = 1'b1;
        start_b    = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        cyc = 0;
        while (done_b !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        n_vec++;
        if (cyc != 17 || done_b !== 1'b1) begin
            n_err++;
            $display("FAIL delay_b_latency: done after %0d edges want 17", cyc);
        end
        n_vec++;
        if ({pass_b, observed_b, mask_b} !== {1'b0, 8'hB0, 8'hE8}) begin
            n_err++;
            $display("FAIL delay_b_result: pass/obs/mask got %b/%h/%h want 0/b0/e8",
                     pass_b, observed_b, mask_b);
        end
        dly_sel_b = 1'b0;
        // C: three settle cycles cover the delay.
        tbl_c      = 8'h58;
        expected_c = 8'h58;
        start_c    = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        cyc = 0;
        while (done_c !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        n_vec++;
        if (cyc != 33 || done_c !== 1'b1) begin
            n_err++;
            $display("FAIL delay_c_latency: done after %0d edges want 33", cyc);
        end
        n_vec++;
        if ({pass_c, observed_c, mask_c} !== {1'b1, 8'h58, 8'h00}) begin
            n_err++;
            $display("FAIL delay_c_result: pass/obs/mask got %b/%h/%h want 1/58/00",
                     pass_c, observed_c, mask_c);
        end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        expected_a = 8'h00; expected_b = 8'h00; expected_c = 8'h00;
        tbl_a = 8'h00; tbl_b = 8'h00; tbl_c = 8'h00;
        dly_sel_b = 1'b0;
        test_reset();
        test_basic();
        test_restart_ignored();
        test_mismatch();
        test_rst_mid();
        test_back_to_back();
        test_delay();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
